accel_spi_responder: RTL
========================

Name: accel_spi_responder

Overview:
- Synthesizable 3-wire SPI responder (mode 3) that emulates the accelerometer on the same conduit the SoPC's SPI initiator drives: SCLK, CS_N, bidirectional SDAT and INT.
- Used in simulation and loopback builds in place of the physical sensor.
- Register map is accelerometer-compatible: device ID, configuration scratch registers and six sample data bytes fed from a sample-injection port.
- Raises a data-ready interrupt whenever a new sample is loaded.

Parameters:
- DEVID, 8'hE5: value returned at address 0x00.
- SYNC_STAGES, 2: synchronizer depth on SCLK, CS_N and SDAT inputs (minimum 2).

Ports:
- clk  in  1  system clock; SCLK must be at most clk/8.
- reset  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock from initiator; idles high.
- spi_cs_n  in  1  chip select, active low.
- spi_sdat_i  in  1  SDAT input from pad.
- spi_sdat_o  out  1  SDAT output value.
- spi_sdat_oe  out  1  SDAT output enable; the pad is driven only when this is 1.
- spi_int  out  1  data-ready interrupt, active high.
- sample_x  in  16  X sample.
- sample_y  in  16  Y sample.
- sample_z  in  16  Z sample.
- sample_valid  in  1  one-cycle strobe that loads sample_x, sample_y and sample_z.
- cfg_wr  out  1  one-cycle pulse on each completed write byte to a writable register.
- cfg_addr  out  6  address of that write.
- cfg_wdata  out  8  data of that write.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - spi_sdat_o=0, spi_sdat_oe=0, spi_int=0, cfg_wr=0, cfg_addr=0, cfg_wdata=0.
  - Scratch registers = 0; data registers = 0.
  - FSM in IDLE; pending-sample flag clear.
- Input handling: inputs pass through SYNC_STAGES flops. SCLK rise and fall are detected from the last two synchronized samples.
- Register map:
  - 0x00: DEVID, read-only.
  - 0x1E..0x31: read/write scratch.
  - 0x32..0x37: read-only, in order X low, X high, Y low, Y high, Z low, Z high.
  - All other addresses read 0x00; writes to them are ignored with no cfg_wr.
- FSM states: IDLE, CMD, RD, WR.
  - IDLE -> CMD on synchronized CS_N falling edge; bit counter cleared.
  - CMD: 8 bits are sampled MSB first on SCLK rises: bit7 R/W (1 = read), bit6 MB, bits5:0 address.
  - After the 8th rise, the FSM enters RD or WR.
- RD state:
  - On the next SCLK fall, spi_sdat_oe=1 and the MSB of the addressed byte is driven.
  - Each subsequent fall shifts out the next bit.
  - After 8 falls, the next byte is loaded at the following fall.
- WR state:
  - 8 rises assemble one byte.
  - On the 8th rise: if the address is writable, the register is updated and cfg_wr pulses one clk with cfg_addr and cfg_wdata.
- Multi-byte: with MB=1 the address increments after each byte and wraps 0x3F -> 0x00. With MB=0 the address is held.
- Read coherency: on entry to RD, all six data bytes are copied into a shadow; every data-register read in that transaction uses the shadow.
- Sample loading:
  - sample_valid while CS_N is high (synchronized) loads the data registers and sets spi_int the following cycle.
  - sample_valid while CS_N is low is held in a one-deep pending slot; a newer strobe overwrites it.
  - The pending sample is applied, and spi_int is set, on the cycle after CS_N rises.
- INT clear:
  - spi_int clears when a read transaction transfers any byte in 0x32..0x37. The clear takes effect at the CS_N rise.
  - If a pending sample is applied in the same cycle, the set wins.
- Abort:
  - CS_N rise in any state returns the FSM to IDLE, with spi_sdat_oe=0 within SYNC_STAGES+1 clk.
  - A partially received write byte is discarded: no register update, no cfg_wr.
- Reset mid-transaction: the FSM returns to IDLE and oe drops the next cycle. The transaction resumes only on a fresh CS_N fall.
- SCLK edges while CS_N is high are ignored.

Optional Feature:
- ACCEL_RESP_INT_ENABLE_EN.
- Defined: spi_int = data_ready AND bit7 of scratch register 0x2E (INT_ENABLE). data_ready still sets and clears internally as above.
- Undefined: spi_int = data_ready unconditionally, and 0x2E is a plain scratch register.

Test Plan:
- DEVID read: CS_N low, command 0x80, 8 more clocks -> responder drives 0xE5; spi_sdat_oe=0 after CS_N rises.
- Write then readback:
  - Write command 0x2D with data 0x08 -> cfg_wr one pulse, cfg_addr=0x2D, cfg_wdata=0x08.
  - Read command 0xAD -> 0x08.
- Burst sample read:
  - sample_x=0x1234, sample_y=0xFFFE, sample_z=0x0100 with sample_valid, then spi_int=1.
  - Read command 0xF2 with 6 bytes -> 34 12 FE FF 00 01; spi_int=0 after CS_N rises.
- Sample during transaction:
  - sample_valid with X=0xAAAA mid-burst -> the burst still returns the old bytes; spi_int rises the cycle after CS_N rises.
  - The next read returns AA AA.
- Abort mid-write: command 0x1E plus 4 data bits, then CS_N rises -> no cfg_wr; a readback of 0x1E returns the old value.
- Wrap: MB read from 0x3F for 2 bytes -> 0x00, then 0xE5.

Source files
------------

// File: rtl/accel_spi_responder.sv
// accel_spi_responder: 3-wire mode-3 SPI accelerometer emulator.
// Optional: ACCEL_RESP_INT_ENABLE_EN gates spi_int with bit7 of reg 0x2E.
module accel_spi_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdat_i,
  output logic        spi_sdat_o,
  output logic        spi_sdat_oe,
  output logic        spi_int,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        cfg_wr,
  output logic [5:0]  cfg_addr,
  output logic [7:0]  cfg_wdata
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RD,
    WR
  } state_t;

  state_t state;

  logic [SYNC_STAGES:0]   sclk_p;
  logic [SYNC_STAGES:0]   cs_p;
  logic [SYNC_STAGES-1:0] sdat_p;

  logic sclk_s, sclk_q, cs_s, cs_q, sdat_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [2:0] cnt;
  logic [6:0] sr;
  logic [7:0] tx;
  logic [5:0] addr;
  logic       mb;
  logic       int_clr;

  logic [7:0] scratch [0:19];
  logic [7:0] data    [0:5];
  logic [7:0] shadow  [0:5];
  logic [7:0] pdata   [0:5];
  logic [7:0] smp     [0:5];
  logic       pend;
  logic       data_ready;

  logic [7:0] wbyte;
  logic [7:0] rdata;
  logic       scr_hit, dat_hit;
  logic [4:0] soff;
  logic [2:0] doff;

  // Input synchronizers; CS_N resets low so a held-low select never looks like a fresh fall
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_p <= '1;
      cs_p   <= '0;
      sdat_p <= '0;
    end else begin
      sclk_p <= {sclk_p[SYNC_STAGES-1:0], spi_sclk};
      cs_p   <= {cs_p[SYNC_STAGES-1:0], spi_cs_n};
      sdat_p <= {sdat_p[SYNC_STAGES-2:0], spi_sdat_i};
    end
  end

  assign sclk_s    = sclk_p[SYNC_STAGES-1];
  assign sclk_q    = sclk_p[SYNC_STAGES];
  assign cs_s      = cs_p[SYNC_STAGES-1];
  assign cs_q      = cs_p[SYNC_STAGES];
  assign sdat_s    = sdat_p[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

  assign wbyte   = {sr, sdat_s};
  assign scr_hit = (addr >= 6'h1E) && (addr <= 6'h31);
  assign dat_hit = (addr >= 6'h32) && (addr <= 6'h37);
  assign soff    = 5'(addr - 6'h1E);
  assign doff    = 3'(addr - 6'h32);

  // Read mux over the register map; data bytes come from the shadow
  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      (addr == 6'h00): rdata = DEVID;
      scr_hit:         rdata = scratch[soff];
      dat_hit:         rdata = shadow[doff];
      default:         rdata = 8'h00;
    endcase
  end

  // Incoming sample split into register byte order
  always_comb begin
    smp[0] = sample_x[7:0];
    smp[1] = sample_x[15:8];
    smp[2] = sample_y[7:0];
    smp[3] = sample_y[15:8];
    smp[4] = sample_z[7:0];
    smp[5] = sample_z[15:8];
  end

  // SPI transaction FSM, scratch writes and serial output
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      tx          <= '0;
      addr        <= '0;
      mb          <= 1'b0;
      int_clr     <= 1'b0;
      spi_sdat_o  <= 1'b0;
      spi_sdat_oe <= 1'b0;
      cfg_wr      <= 1'b0;
      cfg_addr    <= '0;
      cfg_wdata   <= '0;
      for (int i = 0; i < 20; i++) scratch[i] <= '0;
      for (int i = 0; i < 6; i++) shadow[i] <= '0;
    end else begin
      cfg_wr <= 1'b0;
      if (cs_rise) begin
        state       <= IDLE;
        spi_sdat_oe <= 1'b0;
        spi_sdat_o  <= 1'b0;
        int_clr     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cs_fall) begin
              state <= CMD;
              cnt   <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              sr  <= wbyte[6:0];
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                mb   <= wbyte[6];
                addr <= wbyte[5:0];
                if (wbyte[7]) begin
                  state  <= RD;
                  shadow <= data;
                end else begin
                  state <= WR;
                end
              end
            end
          end
          RD: begin
            if (sclk_fall) begin
              spi_sdat_oe <= 1'b1;
              cnt         <= cnt + 3'd1;
              if (cnt == 3'd0) begin
                spi_sdat_o <= rdata[7];
                tx         <= {rdata[6:0], 1'b0};
                if (dat_hit) int_clr <= 1'b1;
              end else begin
                spi_sdat_o <= tx[7];
                tx         <= {tx[6:0], 1'b0};
              end
              if (cnt == 3'd7 && mb) addr <= addr + 6'd1;
            end
          end
          WR: begin
            if (sclk_rise) begin
              sr  <= wbyte[6:0];
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                if (scr_hit) begin
                  scratch[soff] <= wbyte;
                  cfg_wr        <= 1'b1;
                  cfg_addr      <= addr;
                  cfg_wdata     <= wbyte;
                end
                if (mb) addr <= addr + 6'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Sample loading, pending slot and data-ready flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= 1'b0;
      data_ready <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        data[i]  <= '0;
        pdata[i] <= '0;
      end
    end else begin
      if (cs_rise) begin
        if (int_clr) data_ready <= 1'b0;
        if (pend) begin
          data       <= pdata;
          data_ready <= 1'b1;
          pend       <= 1'b0;
        end
      end
      if (sample_valid) begin
        if (cs_s) begin
          data       <= smp;
          data_ready <= 1'b1;
        end else begin
          pdata <= smp;
          pend  <= 1'b1;
        end
      end
    end
  end

`ifdef ACCEL_RESP_INT_ENABLE_EN
  assign spi_int = data_ready & scratch[16][7];
`else
  assign spi_int = data_ready;
`endif

endmodule
